frame_accumulator: RTL and testbench
====================================

# frame_accumulator

Multi-channel, parametrised frame accumulator for the skin-colour segmentation pipeline. It sums per-pixel values (e.g. mask-weighted x, y, and mask count) over a frame while `ce` is asserted, and counts the accepted samples. At end-of-frame it latches the totals into a held output register behind a valid/ready handshake, then restarts from zero without losing a cycle. It supersedes the single-channel, wrap-only running summator and feeds the centroid/moment divider stage.

## Interface
- `IN_W`, 10, width of each unsigned input sample
- `ACC_W`, 28, width of each channel accumulator and output sum; must be ≥ `IN_W`
- `CH`, 3, number of parallel channels; must be ≥ 1
- `CNT_W`, 22, width of the accepted-sample counter
- `clk`  in  1  single clock; all logic on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `ce`  in  1  sample enable; when high, `a` is accumulated and counted
- `eof`  in  1  end-of-frame pulse; closes the current frame
- `a`  in  `CH*IN_W`  packed samples; channel k is `a[k*IN_W +: IN_W]`, unsigned
- `sums`  out  `CH*ACC_W`  latched frame totals, same packing as `a`
- `count`  out  `CNT_W`  latched number of `ce` cycles in the frame
- `out_valid`  out  1  latched totals available
- `out_ready`  in  1  consumer accepts the totals
- `overrun`  out  1  sticky; a frame result was overwritten before it was accepted
- `sat`  out  `CH`  sticky per-channel saturation flags for the latched frame

## Operation
- Running state: `acc[k]` (ACC_W) and `cnt` (CNT_W). Both are internal and not exported.
- On a cycle with `ce=1, eof=0`:
  - `acc[k] <= acc[k] + zero_ext(a_k)`
  - `cnt <= cnt + 1`
- On a cycle with `eof=1` (frame close):
  - `sums[k] <= acc[k] + (ce ? a_k : 0)`
  - `count <= cnt + ce`
  - `out_valid <= 1`
  - `acc`, `cnt`, and the running sat flags are cleared to 0.
  - The `eof` cycle's sample belongs to the closing frame.
- An `eof` with zero prior `ce` cycles produces a valid result with all sums and `count` equal to 0.
- Handshake:
  - `out_valid` stays high, with `sums`/`count`/`sat` held stable, until a cycle where `out_valid & out_ready`.
  - On that cycle `out_valid` drops next cycle, unless `eof` occurs in the same cycle.
  - If `eof` and accept occur in the same cycle, the new result loads and `out_valid` stays 1. No overrun.
- Overrun: `eof` while `out_valid=1` and `out_ready=0` overwrites the held result and sets `overrun <= 1`. `overrun` clears only on `rst`.
- Arithmetic: unsigned and modulo-2^width unless `FRAME_ACC_SAT_EN` is defined (see Configuration).
- Reset (any cycle, including mid-frame or while `out_valid` is high): all outputs and state go to 0 on the next edge: `sums=0`, `count=0`, `out_valid=0`, `overrun=0`, `sat=0`. Inputs sampled in the reset cycle are discarded. `rst` has priority over `eof` and `ce`.

## Timing
- Accumulation latency: 1 cycle (a sample at edge t is in `acc` after edge t).
- Result latency: `eof` sampled at edge t → `out_valid=1` with totals visible after edge t.
- The first sample of the next frame may arrive in the cycle immediately after `eof`. There is no dead cycle.
- `out_ready` is a combinational input only into registered state. There is no combinational path from inputs to outputs.
- Back-to-back `eof` on consecutive cycles is legal. The second result contains only the second cycle's sample.

## Configuration
- `FRAME_ACC_SAT_EN` defined:
  - Each channel add clamps at 2^ACC_W−1 and sets that channel's running sat flag. The flag is latched into `sat[k]` at frame close.
  - `cnt` clamps at 2^CNT_W−1.
- `FRAME_ACC_SAT_EN` not defined:
  - Adds and `cnt` wrap modulo 2^width.
  - `sat` is constant 0.
  - No comparison logic is generated.

## Structure
- Package `frame_acc_pkg`: default constants `IN_W_DEF=10`, `ACC_W_DEF=28`, `CH_DEF=3`, `CNT_W_DEF=22`.
- Sub-module `acc_channel`:
  - Contents: one accumulator, close/clear logic, and optional saturation.
  - Parameters: `IN_W`, `ACC_W`.
  - Instantiated `CH` times in a generate loop.
- The counter, handshake, and overrun logic live in the top level.

## Test plan
- CH=3: `ce=1` for 4 cycles with a=(1,2,3), then `eof` with ce=0 → `sums`=(4,8,12), `count`=4, `out_valid`=1 next cycle.
- `eof` and `ce` together with a=(5,0,7) after 2 samples of (1,1,1) → `sums`=(7,2,9), `count`=3. The next frame starts at 0.
- Hold `out_ready=0`, issue two `eof`s → second result replaces first, `overrun`=1. Assert `out_ready` → `out_valid` drops; `overrun` stays 1 until `rst`.
- ACC_W=12, IN_W=10, 5 samples of 1023 → with the macro: sum=4095, `sat[k]=1`. Without: sum=5115 mod 4096=1019, `sat=0`.
- `rst` mid-frame after 3 samples, then 2 samples of (2,2,2) and `eof` → `sums`=(4,4,4), `count`=2. All outputs are 0 during and after reset.
- `eof` on a cycle with `out_valid & out_ready` → `out_valid` stays 1, new totals load, `overrun`=0.

Source files
------------

// File: rtl/frame_acc_pkg.sv
// rtl/frame_acc_pkg.sv - default parameter constants for the frame accumulator
package frame_acc_pkg;
  localparam int IN_W_DEF  = 10;
  localparam int ACC_W_DEF = 28;
  localparam int CH_DEF    = 3;
  localparam int CNT_W_DEF = 22;
endpackage

// File: rtl/acc_channel.sv
// rtl/acc_channel.sv - one channel accumulator with frame close/clear; FRAME_ACC_SAT_EN enables clamping
module acc_channel
  import frame_acc_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             eof,
  input  logic [IN_W-1:0]  a,
  output logic [ACC_W-1:0] sum,
  output logic             sat
);
  logic [ACC_W-1:0] acc_q, acc_d, sum_q, addend;

  // The eof-cycle sample belongs to the closing frame, so acc_d already includes it.
  assign addend = ce ? ACC_W'(a) : '0;
  assign sum    = sum_q;

`ifdef FRAME_ACC_SAT_EN
  logic [ACC_W:0] wide;
  logic           ovf;
  logic           run_sat_q, sat_q;

  assign wide  = {1'b0, acc_q} + {1'b0, addend};
  assign ovf   = wide[ACC_W];
  assign acc_d = ovf ? '1 : wide[ACC_W-1:0];
  assign sat   = sat_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      sum_q     <= '0;
      run_sat_q <= 1'b0;
      sat_q     <= 1'b0;
    end else if (eof) begin
      sum_q     <= acc_d;
      sat_q     <= run_sat_q | ovf;
      acc_q     <= '0;
      run_sat_q <= 1'b0;
    end else if (ce) begin
      acc_q     <= acc_d;
      run_sat_q <= run_sat_q | ovf;
    end
  end
`else
  assign acc_d = acc_q + addend;
  assign sat   = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      sum_q <= '0;
    end else if (eof) begin
      sum_q <= acc_d;
      acc_q <= '0;
    end else if (ce) begin
      acc_q <= acc_d;
    end
  end
`endif
endmodule

// File: rtl/frame_accumulator.sv
// rtl/frame_accumulator.sv - multi-channel frame accumulator with held result and valid/ready; FRAME_ACC_SAT_EN enables clamping
module frame_accumulator
  import frame_acc_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int CH    = CH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              eof,
  input  logic [CH*IN_W-1:0]  a,
  output logic [CH*ACC_W-1:0] sums,
  output logic [CNT_W-1:0]    count,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun,
  output logic [CH-1:0]     sat
);
  logic [CNT_W-1:0] cnt_q, cnt_d, count_q;
  logic             valid_q, overrun_q;

  for (genvar k = 0; k < CH; k++) begin : g_ch
    acc_channel #(.IN_W(IN_W), .ACC_W(ACC_W)) u_ch (
      .clk (clk),
      .rst (rst),
      .ce  (ce),
      .eof (eof),
      .a   (a[k*IN_W +: IN_W]),
      .sum (sums[k*ACC_W +: ACC_W]),
      .sat (sat[k])
    );
  end

`ifdef FRAME_ACC_SAT_EN
  assign cnt_d = (ce && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
`else
  assign cnt_d = cnt_q + CNT_W'(ce);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else if (eof) begin
      count_q <= cnt_d;
      cnt_q   <= '0;
      valid_q <= 1'b1;
      // Same-cycle accept frees the slot, so only an unaccepted held result is lost.
      if (valid_q && !out_ready) overrun_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      if (valid_q && out_ready) valid_q <= 1'b0;
    end
  end

  assign count     = count_q;
  assign out_valid = valid_q;
  assign overrun   = overrun_q;
endmodule

// File: tb/tb_frame_accumulator.sv
// tb/tb_frame_accumulator.sv - directed self-checking bench for frame_accumulator
module tb_frame_accumulator;
  localparam int IN_W  = 10;
  localparam int ACC_W = 12;
  localparam int CH    = 3;
  localparam int CNT_W = 22;

  logic                clk = 1'b0;
  logic                rst, ce, eof, out_ready;
  logic [CH*IN_W-1:0]  a;
  logic [CH*ACC_W-1:0] sums;
  logic [CNT_W-1:0]    count;
  logic                out_valid, overrun;
  logic [CH-1:0]       sat;

  int checks = 0;
  int errors = 0;

  frame_accumulator #(.IN_W(IN_W), .ACC_W(ACC_W), .CH(CH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .eof       (eof),
    .a         (a),
    .sums      (sums),
    .count     (count),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun),
    .sat       (sat)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input int x0, input int x1, input int x2);
    a = {IN_W'(x2), IN_W'(x1), IN_W'(x0)};
  endtask

  function automatic int ch_sum(input int k);
    return int'(sums[k*ACC_W +: ACC_W]);
  endfunction

  task automatic test_reset();
    rst = 1'b1; ce = 1'b1; eof = 1'b1; out_ready = 1'b0; set_a(7, 7, 7);
    step();
    rst = 1'b0; ce = 1'b0; eof = 1'b0;
    checks++; if (sums !== '0) begin errors++; $display("FAIL reset_sums got %h want 0", sums); end
    checks++; if (count !== '0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
    checks++; if (sat !== '0) begin errors++; $display("FAIL reset_sat got %b want 0", sat); end
  endtask

  task automatic test_basic();
    int exp [3] = '{4, 8, 12};
    ce = 1'b1; set_a(1, 2, 3);
    for (int i = 0; i < 4; i++) step();
    ce = 1'b0; eof = 1'b1;
    step();
    eof = 1'b0;
    for (int k = 0; k < CH; k++) begin
      checks++; if (ch_sum(k) !== exp[k]) begin errors++; $display("FAIL basic_sum%0d got %0d want %0d", k, ch_sum(k), exp[k]); end
    end
    checks++; if (count !== 4) begin errors++; $display("FAIL basic_count got %0d want 4", count); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", out_valid); end
    step();
    checks++; if (out_valid !== 1'b1 || ch_sum(2) !== 12) begin errors++; $display("FAIL basic_hold got valid %b sum2 %0d want 1 12", out_valid, ch_sum(2)); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_accept got %b want 0", out_valid); end
  endtask

  task automatic test_eof_with_ce();
    int exp [3] = '{7, 2, 9};
    ce = 1'b1; set_a(1, 1, 1);
    step(); step();
    set_a(5, 0, 7); eof = 1'b1;
    step();
    ce = 1'b0; eof = 1'b0;
    for (int k = 0; k < CH; k++) begin
      checks++; if (ch_sum(k) !== exp[k]) begin errors++; $display("FAIL eofce_sum%0d got %0d want %0d", k, ch_sum(k), exp[k]); end
    end
    checks++; if (count !== 3) begin errors++; $display("FAIL eofce_count got %0d want 3", count); end
    // Empty frame closed on the same cycle the held result is accepted.
    out_ready = 1'b1; eof = 1'b1;
    step();
    eof = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL accept_eof_valid got %b want 1", out_valid); end
    checks++; if (sums !== '0 || count !== '0) begin errors++; $display("FAIL accept_eof_zero got sums %h count %0d want 0 0", sums, count); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL accept_eof_overrun got %b want 0", overrun); end
    step();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL accept_drop got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back_overrun();
    out_ready = 1'b0; ce = 1'b1; eof = 1'b1; set_a(1, 2, 3);
    step();
    set_a(9, 8, 6);
    step();
    ce = 1'b0; eof = 1'b0;
    checks++; if (ch_sum(0) !== 9 || ch_sum(1) !== 8 || ch_sum(2) !== 6) begin errors++; $display("FAIL b2b_sums got %0d %0d %0d want 9 8 6", ch_sum(0), ch_sum(1), ch_sum(2)); end
    checks++; if (count !== 1) begin errors++; $display("FAIL b2b_count got %0d want 1", count); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set got %b want 1", overrun); end
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL overrun_accept got %b want 0", out_valid); end
    step();
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky got %b want 1", overrun); end
  endtask

  task automatic test_saturation();
    int exp_sum;
    logic [CH-1:0] exp_sat;
`ifdef FRAME_ACC_SAT_EN
    exp_sum = 4095; exp_sat = '1;
`else
    exp_sum = 1019; exp_sat = '0;
`endif
    out_ready = 1'b1; ce = 1'b1; set_a(1023, 1023, 1023);
    for (int i = 0; i < 5; i++) step();
    ce = 1'b0; eof = 1'b1;
    step();
    eof = 1'b0;
    for (int k = 0; k < CH; k++) begin
      checks++; if (ch_sum(k) !== exp_sum) begin errors++; $display("FAIL sat_sum%0d got %0d want %0d", k, ch_sum(k), exp_sum); end
    end
    checks++; if (sat !== exp_sat) begin errors++; $display("FAIL sat_flags got %b want %b", sat, exp_sat); end
    checks++; if (count !== 5) begin errors++; $display("FAIL sat_count got %0d want 5", count); end
    step();
  endtask

  task automatic test_reset_mid_frame();
    out_ready = 1'b0; ce = 1'b1; set_a(1, 1, 1);
    step(); step(); step();
    eof = 1'b1; step();
    eof = 1'b0;
    rst = 1'b1;
    step();
    checks++; if (sums !== '0 || count !== '0 || out_valid !== 1'b0 || overrun !== 1'b0 || sat !== '0)
      begin errors++; $display("FAIL rst_during got sums %h count %0d valid %b ovr %b sat %b want all 0", sums, count, out_valid, overrun, sat); end
    rst = 1'b0; ce = 1'b0;
    step();
    checks++; if (sums !== '0 || count !== '0 || out_valid !== 1'b0 || overrun !== 1'b0)
      begin errors++; $display("FAIL rst_after got sums %h count %0d valid %b ovr %b want all 0", sums, count, out_valid, overrun); end
    ce = 1'b1; set_a(2, 2, 2);
    step(); step();
    ce = 1'b0; eof = 1'b1;
    step();
    eof = 1'b0;
    checks++; if (ch_sum(0) !== 4 || ch_sum(1) !== 4 || ch_sum(2) !== 4) begin errors++; $display("FAIL rst_frame_sums got %0d %0d %0d want 4 4 4", ch_sum(0), ch_sum(1), ch_sum(2)); end
    checks++; if (count !== 2) begin errors++; $display("FAIL rst_frame_count got %0d want 2", count); end
    checks++; if (overrun !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL rst_frame_flags got ovr %b valid %b want 0 1", overrun, out_valid); end
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; eof = 1'b0; out_ready = 1'b0; a = '0;
    test_reset();
    test_basic();
    test_eof_with_ce();
    test_back_to_back_overrun();
    test_saturation();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
